esp_frame_rx: RTL and testbench

//   Frame deframer sitting directly downstream of UART_COM's receive stream (rx_data/rx_valid/rx_ready).

---
 rtl/esp_frame_rx.sv | 134 +++++++++++++
 tb/tb_esp_frame_rx.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/esp_frame_rx.sv
// rtl/esp_frame_rx.sv - SOF/LEN/PAYLOAD/CHK deframer on a valid/ready byte stream.
// Buffers one frame, verifies its XOR checksum, then drains the payload downstream.
module esp_frame_rx #(
  parameter logic [7:0] SOF_BYTE       = 8'h7E,
  parameter int         MAX_LEN        = 32,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic [7:0] frame_len,
  output logic       chk_err,
  output logic       len_err,
  output logic       timeout_err
);

  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);

  typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHK, S_DRAIN} state_t;

  state_t          state, state_nxt;
  logic            ready_en;
  logic [7:0]      mem [MAX_LEN];
  logic [IW-1:0]   wr_idx, rd_idx;
  logic [7:0]      len_q, chk;
  logic [TW-1:0]   timer;
  logic            accept, xfer, in_frame, to_hit, len_bad, chk_bad, chk_ok;

  always_comb begin
    state_nxt = state;
    out_data  = 8'h00;
    out_last  = 1'b0;
    frame_len = 8'h00;
    len_bad   = 1'b0;
    chk_bad   = 1'b0;
    chk_ok    = 1'b0;

    // ready_en keeps in_ready low for the reset cycle itself
    in_ready  = ready_en && (state != S_DRAIN);
    out_valid = (state == S_DRAIN);
    if (out_valid) begin
      out_data  = mem[rd_idx[AW-1:0]];
      out_last  = (8'(rd_idx) == len_q - 8'd1);
      frame_len = len_q;
    end
    accept   = in_valid && in_ready;
    xfer     = out_valid && out_ready;
    in_frame = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
    to_hit   = in_frame && !accept && (timer == TW'(TIMEOUT_CYCLES - 1));

    case (state)
      S_HUNT: if (accept && in_data == SOF_BYTE) state_nxt = S_LEN;
      S_LEN: begin
        if (accept) begin
          if (in_data == 8'h00 || {1'b0, in_data} > MAX_LEN_W) begin
            len_bad   = 1'b1;
            state_nxt = S_HUNT;
          end else begin
            state_nxt = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: if (accept && 8'(wr_idx) == len_q - 8'd1) state_nxt = S_CHK;
      S_CHK: begin
        if (accept) begin
          chk_ok    = (in_data == chk);
          chk_bad   = !chk_ok;
          state_nxt = chk_ok ? S_DRAIN : S_HUNT;
        end
      end
      S_DRAIN: if (xfer && out_last) state_nxt = S_HUNT;
      default: state_nxt = S_HUNT;
    endcase
    if (to_hit) state_nxt = S_HUNT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_HUNT;
      ready_en    <= 1'b0;
      wr_idx      <= '0;
      rd_idx      <= '0;
      len_q       <= 8'h00;
      chk         <= 8'h00;
      timer       <= '0;
      chk_err     <= 1'b0;
      len_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      ready_en    <= 1'b1;
      chk_err     <= chk_bad;
      len_err     <= len_bad;
      timeout_err <= to_hit;

      if (accept || !in_frame || to_hit) timer <= '0;
      else                               timer <= timer + 1'b1;

      case (state)
        S_LEN: begin
          if (accept) begin
            len_q  <= in_data;
            chk    <= in_data;
            wr_idx <= '0;
          end
        end
        S_PAYLOAD: begin
          if (accept) begin
            chk    <= chk ^ in_data;
            wr_idx <= wr_idx + 1'b1;
          end
        end
        S_CHK:   if (chk_ok) rd_idx <= '0;
        S_DRAIN: if (xfer) rd_idx <= rd_idx + 1'b1;
        default: ;
      endcase
    end
  end

  // Payload storage needs no reset: it is only read after a full frame is written.
  always_ff @(posedge clk) begin
    if (state == S_PAYLOAD && accept) mem[wr_idx[AW-1:0]] <= in_data;
  end

endmodule

// File: tb/tb_esp_frame_rx.sv
// tb/tb_esp_frame_rx.sv - self-checking bench for esp_frame_rx.
module tb_esp_frame_rx;

  localparam int MAX_LEN = 8;
  localparam int TO      = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic [7:0] frame_len;
  logic       chk_err, len_err, timeout_err;

  always #5 clk = ~clk;

  esp_frame_rx #(.SOF_BYTE(8'h7E), .MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .frame_len(frame_len),
    .chk_err(chk_err), .len_err(len_err), .timeout_err(timeout_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic       last;
    logic [7:0] flen;
    logic [7:0] data;
  } obs_t;

  obs_t got[$];
  obs_t exp_q[$];
  int   chk_cnt = 0, len_cnt = 0, to_cnt = 0, stall_cnt = 0;
  int   exp_chk, exp_len;

  logic       pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [7:0] pd = 8'h00, pf = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (out_valid) check("in_ready_low_in_drain", 32'(in_ready), 32'd0);
      if (pv && !pr) begin
        stall_cnt++;
        check("stall_valid_held", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(pd));
        check("stall_last", 32'(out_last), 32'(pl));
        check("stall_flen", 32'(frame_len), 32'(pf));
      end
      if (out_valid && out_ready) got.push_back({out_last, frame_len, out_data});
      if (chk_err) chk_cnt++;
      if (len_err) len_cnt++;
      if (timeout_err) to_cnt++;
      if (chk_err || len_err || timeout_err)
        check("err_onehot", 32'($onehot({chk_err, len_err, timeout_err})), 32'd1);
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last; pf = frame_len;
    end
  end

  int   ready_mode = 0;
  logic ready_pat[$];

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (out_valid && ready_pat.size() > 0) out_ready = ready_pat.pop_front();
      else if (ready_mode == 0)              out_ready = 1'b1;
      else if (ready_mode == 1)              out_ready = 1'($urandom_range(0, 1));
      else                                   out_ready = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int   w;
    logic acc;
    in_data  = b;
    in_valid = 1'b1;
    w = 0;
    while (1) begin
      acc = in_ready;
      tick();
      if (acc) break;
      w++;
      if (w > 2000) begin
        check("send_byte_bound", 32'd0, 32'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    for (k = 0; k < 3000; k++) begin
      if (!out_valid) break;
      tick();
    end
    if (k == 3000) check("drain_bound", 32'd0, 32'd1);
    repeat (3) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_frame_len", 32'(frame_len), 32'd0);
    check("rst_errs", 32'({chk_err, len_err, timeout_err}), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("in_ready_after_rst", 32'(in_ready), 32'd1);
  endtask

  logic [7:0] stream[$];

  // Reference parse of a complete byte stream: frame-level rules only.
  task automatic model();
    int i, n, L;
    logic [7:0] x;
    exp_q.delete();
    exp_chk = 0;
    exp_len = 0;
    i = 0;
    n = stream.size();
    while (i < n) begin
      if (stream[i] != 8'h7E) begin i++; continue; end
      if (i + 1 >= n) break;
      L = int'(stream[i+1]);
      if (L == 0 || L > MAX_LEN) begin exp_len++; i += 2; continue; end
      if (i + 2 + L >= n) break;
      x = stream[i+1];
      for (int k = 0; k < L; k++) x ^= stream[i+2+k];
      if (x == stream[i+2+L]) begin
        for (int k = 0; k < L; k++) exp_q.push_back({(k == L - 1), 8'(L), stream[i+2+k]});
      end else begin
        exp_chk++;
      end
      i += 3 + L;
    end
  endtask

  typedef struct {
    string        name;
    int           n_in;
    logic [191:0] in_b;
    int           n_out;
    logic [63:0]  out_b;
    logic [7:0]   last_m;
    logic [7:0]   flen;
    int           n_chk;
    int           n_len;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int base, c0, l0, t0, s0, first, pulses;
    logic [7:0] b, L;

    vecs[0] = '{"basic3", 6, 192'h7E_03_11_22_33_03, 3, 64'h11_22_33, 8'b100, 8'd3, 0, 0};
    vecs[1] = '{"bad_chk_then_good", 9, 192'h7E_02_AA_BB_00_7E_01_55_54, 1, 64'h55, 8'b1, 8'd1, 1, 0};
    vecs[2] = '{"len_errs_garbage", 12, 192'h00_FF_12_7E_00_7E_09_7E_02_A5_5A_FD, 2, 64'hA5_5A,
                8'b10, 8'd2, 0, 2};
    vecs[3] = '{"sof_in_payload", 5, 192'h7E_02_7E_7E_02, 2, 64'h7E_7E, 8'b10, 8'd2, 0, 0};
    vecs[4] = '{"two_frames", 8, 192'h7E_01_10_11_7E_01_20_21, 2, 64'h10_20, 8'b11, 8'd1, 0, 0};
    vecs[5] = '{"max_len", 11, 192'h7E_08_01_02_04_08_10_20_40_80_F7, 8, 64'h01_02_04_08_10_20_40_80,
                8'h80, 8'd8, 0, 0};
    vecs[6] = '{"len_ff_sof_as_len", 8, 192'h7E_FF_7E_7E_7E_01_7E_7F, 1, 64'h7E, 8'b1, 8'd1, 0, 2};

    in_valid = 1'b0;
    in_data  = 8'h00;
    rst      = 1'b1;
    tick();
    do_reset();

    foreach (vecs[v]) begin
      base = got.size(); c0 = chk_cnt; l0 = len_cnt; t0 = to_cnt;
      for (int i = 0; i < vecs[v].n_in; i++) send_byte(vecs[v].in_b[(vecs[v].n_in-1-i)*8 +: 8]);
      wait_drain();
      check({vecs[v].name, "_count"}, 32'(got.size() - base), 32'(vecs[v].n_out));
      for (int j = 0; j < vecs[v].n_out && base + j < got.size(); j++) begin
        check({vecs[v].name, "_data"}, 32'(got[base+j].data), 32'(vecs[v].out_b[(vecs[v].n_out-1-j)*8 +: 8]));
        check({vecs[v].name, "_last"}, 32'(got[base+j].last), 32'(vecs[v].last_m[j]));
        check({vecs[v].name, "_flen"}, 32'(got[base+j].flen), 32'(vecs[v].flen));
      end
      check({vecs[v].name, "_chk_err"}, 32'(chk_cnt - c0), 32'(vecs[v].n_chk));
      check({vecs[v].name, "_len_err"}, 32'(len_cnt - l0), 32'(vecs[v].n_len));
      check({vecs[v].name, "_timeout_err"}, 32'(to_cnt - t0), 32'd0);
    end

    // Inter-byte timeout inside a frame, then recovery; none while hunting.
    base = got.size(); t0 = to_cnt;
    send_byte(8'h7E); send_byte(8'h04); send_byte(8'h01);
    first = 0; pulses = 0;
    for (int k = 1; k <= 110; k++) begin
      tick();
      if (timeout_err) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
    check("timeout_cycle", 32'(first), 32'(TO));
    check("timeout_pulses", 32'(pulses), 32'd1);
    repeat (150) tick();
    check("no_timeout_in_hunt", 32'(to_cnt - t0), 32'd1);
    send_byte(8'h7E); send_byte(8'h01); send_byte(8'h3C); send_byte(8'h3D);
    wait_drain();
    check("after_timeout_count", 32'(got.size() - base), 32'd1);
    if (got.size() > base) check("after_timeout_data", 32'(got[base]), 32'({1'b1, 8'd1, 8'h3C}));

    // Latency and stall behaviour with out_ready 1,0,0,1.
    base = got.size(); s0 = stall_cnt;
    ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    send_byte(8'h7E); send_byte(8'h03); send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3);
    check("valid_low_before_chk", 32'(out_valid), 32'd0);
    send_byte(8'hD3);
    check("latency_one_cycle", 32'(out_valid), 32'd1);
    wait_drain();
    check("stall_cycles", 32'(stall_cnt - s0), 32'd2);
    check("stall_count", 32'(got.size() - base), 32'd3);
    if (got.size() >= base + 3) begin
      check("stall_b0", 32'(got[base]),   32'({1'b0, 8'd3, 8'hA1}));
      check("stall_b1", 32'(got[base+1]), 32'({1'b0, 8'd3, 8'hB2}));
      check("stall_b2", 32'(got[base+2]), 32'({1'b1, 8'd3, 8'hC3}));
    end

    // Reset mid-payload and mid-drain, then a full MAX_LEN frame.
    base = got.size();
    send_byte(8'h7E); send_byte(8'h05); send_byte(8'h01); send_byte(8'h02);
    do_reset();
    ready_mode = 2;
    send_byte(8'h7E); send_byte(8'h02); send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h64);
    repeat (3) tick();
    check("held_drain_valid", 32'(out_valid), 32'd1);
    check("held_drain_data", 32'(out_data), 32'hAB);
    do_reset();
    ready_mode = 0;
    repeat (3) tick();
    check("no_out_after_rst", 32'(got.size() - base), 32'd0);
    check("valid_low_after_rst", 32'(out_valid), 32'd0);
    send_byte(8'h7E); send_byte(8'h08);
    for (int i = 0; i < 8; i++) send_byte(8'hF0 + 8'(i));
    send_byte(8'h08);
    wait_drain();
    check("maxlen_count", 32'(got.size() - base), 32'd8);
    for (int i = 0; i < 8 && base + i < got.size(); i++)
      check("maxlen_byte", 32'(got[base+i]), 32'({(i == 7), 8'd8, 8'hF0 + 8'(i)}));

    // Randomized frame mix with random gaps and backpressure.
    stream.delete();
    for (int f = 0; f < 40; f++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind <= 7) begin
        L = 8'($urandom_range(1, MAX_LEN));
        stream.push_back(8'h7E);
        stream.push_back(L);
        b = L;
        for (int k = 0; k < int'(L); k++) begin
          logic [7:0] p;
          p = 8'($urandom_range(0, 255));
          stream.push_back(p);
          b ^= p;
        end
        if (kind >= 6) b ^= 8'($urandom_range(1, 255));
        stream.push_back(b);
      end else if (kind == 8) begin
        stream.push_back(8'h7E);
        stream.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
      end else begin
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
          b = 8'($urandom_range(0, 255));
          stream.push_back((b == 8'h7E) ? 8'h00 : b);
        end
      end
    end
    model();
    base = got.size(); c0 = chk_cnt; l0 = len_cnt; t0 = to_cnt;
    ready_mode = 1;
    foreach (stream[i]) begin
      repeat ($urandom_range(0, 3)) tick();
      send_byte(stream[i]);
    end
    wait_drain();
    ready_mode = 0;
    repeat (3) tick();
    check("rand_count", 32'(got.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && base + i < got.size(); i++)
      check("rand_byte", 32'(got[base+i]), 32'(exp_q[i]));
    check("rand_chk_err", 32'(chk_cnt - c0), 32'(exp_chk));
    check("rand_len_err", 32'(len_cnt - l0), 32'(exp_len));
    check("rand_timeout_err", 32'(to_cnt - t0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
